// File: rtl/alu_sequencer_if.sv
// Control-side bus between the sequencer, its program ROM and the ALU datapath.
// master = sequencer, slave = ROM/datapath side.
interface alu_sequencer_if #(
  parameter int WIDTH    = 8,
  parameter int SOURCES  = 4,
  parameter int PC_WIDTH = 6,
  parameter int IWORD    = 5 * WIDTH
) ();
  localparam int SW = (SOURCES > 1) ? $clog2(SOURCES) : 1;

  logic                start;
  logic [PC_WIDTH-1:0] prog_addr;
  logic [IWORD-1:0]    prog_data;
  logic                zero_flag;
  logic [WIDTH-1:0]    op_code;
  logic [WIDTH-1:0]    source1;
  logic [WIDTH-1:0]    source2;
  logic [SW-1:0]       source1_choice;
  logic [SW-1:0]       source2_choice;
  logic [WIDTH-1:0]    destination;
  logic [1:0]          dest_choice;
  logic                push;
  logic                pop;
  logic [PC_WIDTH-1:0] instr_addr;
  logic                busy;
  logic                halted;
  logic                stack_err;

  modport master (
    input  start, prog_data, zero_flag,
    output prog_addr, op_code, source1, source2, source1_choice, source2_choice,
           destination, dest_choice, push, pop, instr_addr, busy, halted, stack_err
  );

  modport slave (
    output start, prog_data, zero_flag,
    input  prog_addr, op_code, source1, source2, source1_choice, source2_choice,
           destination, dest_choice, push, pop, instr_addr, busy, halted, stack_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/decode/issue controller for the ALU datapath: 3 cycles per instruction,
// control-flow opcodes resolved internally with a small return-address stack.
module alu_sequencer #(
  parameter int WIDTH       = 8,
  parameter int SOURCES     = 4,
  parameter int PC_WIDTH    = 6,
  parameter int STACK_DEPTH = 4,
  parameter int IWORD       = 5 * WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  alu_sequencer_if.master bus
);
  localparam int SW   = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  localparam int SPW  = $clog2(STACK_DEPTH + 1);
  localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [WIDTH-1:0] OP_JMP  = WIDTH'(8'hF0);
  localparam logic [WIDTH-1:0] OP_JZ   = WIDTH'(8'hF1);
  localparam logic [WIDTH-1:0] OP_JNZ  = WIDTH'(8'hF2);
  localparam logic [WIDTH-1:0] OP_CALL = WIDTH'(8'hF3);
  localparam logic [WIDTH-1:0] OP_RET  = WIDTH'(8'hF4);
  localparam logic [WIDTH-1:0] OP_HALT = WIDTH'(8'hFF);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t              r_state;
  logic [IWORD-1:0]    r_ir;
  logic [PC_WIDTH-1:0] r_pc;
  logic [SPW-1:0]      r_sp;
  logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];
  logic [WIDTH-1:0]    r_op_code, r_source1, r_source2, r_destination;
  logic [SW-1:0]       r_s1c, r_s2c;
  logic [1:0]          r_dest_choice;
  logic                r_push, r_pop, r_stack_err;

  logic [WIDTH-1:0]    w_dec_op, w_ir_op;
  logic                w_dec_ctrl;
  logic [PC_WIDTH-1:0] w_target, w_pc_inc, w_top;
  logic [SPW-1:0]      w_sp_m1;
  logic                w_full, w_empty;

  assign w_dec_op   = bus.prog_data[IWORD-1 -: WIDTH];
  assign w_dec_ctrl = (w_dec_op >= OP_JMP);
  assign w_ir_op    = r_ir[IWORD-1 -: WIDTH];
  assign w_target   = r_ir[WIDTH +: PC_WIDTH];
  assign w_pc_inc   = r_pc + PC_WIDTH'(1);
  assign w_full     = (r_sp == SPW'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_sp_m1    = r_sp - SPW'(1);
  assign w_top      = r_stack[w_sp_m1[IDXW-1:0]];

  // Strobes and field outputs are set on the DECODE->EXEC edge so they are
  // visible exactly during EXEC; stack/pc updates land on the EXEC edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_ir          <= '0;
      r_pc          <= '0;
      r_sp          <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
      r_op_code     <= '0;
      r_source1     <= '0;
      r_source2     <= '0;
      r_destination <= '0;
      r_s1c         <= '0;
      r_s2c         <= '0;
      r_dest_choice <= 2'b11;
      r_push        <= 1'b0;
      r_pop         <= 1'b0;
      r_stack_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_pc    <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_ir    <= bus.prog_data;
          r_state <= S_EXEC;
          if (!w_dec_ctrl) begin
            r_op_code     <= w_dec_op;
            r_source1     <= bus.prog_data[4*WIDTH-1 -: WIDTH];
            r_source2     <= bus.prog_data[3*WIDTH-1 -: WIDTH];
            r_destination <= bus.prog_data[2*WIDTH-1 -: WIDTH];
            r_s1c         <= SW'(bus.prog_data[7:6]);
            r_s2c         <= SW'(bus.prog_data[5:4]);
            r_dest_choice <= bus.prog_data[3:2];
          end else if (w_dec_op == OP_CALL && !w_full) begin
            r_push <= 1'b1;
          end else if (w_dec_op == OP_RET && !w_empty) begin
            r_pop <= 1'b1;
          end
        end
        S_EXEC: begin
          r_dest_choice <= 2'b11;
          r_push        <= 1'b0;
          r_pop         <= 1'b0;
          r_state       <= S_FETCH;
          case (w_ir_op)
            OP_JMP:  r_pc <= w_target;
            OP_JZ:   r_pc <= bus.zero_flag ? w_target : w_pc_inc;
            OP_JNZ:  r_pc <= bus.zero_flag ? w_pc_inc : w_target;
            OP_CALL: begin
              if (!w_full) begin
                r_stack[r_sp[IDXW-1:0]] <= w_pc_inc;
                r_sp                    <= r_sp + SPW'(1);
                r_pc                    <= w_target;
              end else begin
                r_stack_err <= 1'b1;
                r_state     <= S_HALT;
              end
            end
            OP_RET: begin
              if (!w_empty) begin
                r_pc <= w_top;
                r_sp <= w_sp_m1;
              end else begin
                r_stack_err <= 1'b1;
                r_state     <= S_HALT;
              end
            end
            OP_HALT: r_state <= S_HALT;
            default: r_pc    <= w_pc_inc;
          endcase
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.prog_addr      = r_pc;
  assign bus.instr_addr     = r_pc;
  assign bus.op_code        = r_op_code;
  assign bus.source1        = r_source1;
  assign bus.source2        = r_source2;
  assign bus.source1_choice = r_s1c;
  assign bus.source2_choice = r_s2c;
  assign bus.destination    = r_destination;
  assign bus.dest_choice    = r_dest_choice;
  assign bus.push           = r_push;
  assign bus.pop            = r_pop;
  assign bus.busy           = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
  assign bus.halted         = (r_state == S_HALT);
  assign bus.stack_err      = r_stack_err;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: instruction-level reference model (pc, return stack
// as a queue, last issued fields) driven by directed and random ROM programs.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();
  alu_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  logic [39:0] rom [64];
  always @(posedge clk) bus.prog_data <= rom[bus.prog_addr];

  int n_pass = 0;
  int n_total = 0;

  int         m_pc;
  int         m_stack [$];
  logic [7:0] m_op, m_s1, m_s2, m_dst;
  logic [1:0] m_c1, m_c2;
  bit         m_halt, m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] mk(input logic [7:0] op, input logic [7:0] s1,
                                     input logic [7:0] s2, input logic [7:0] dst,
                                     input logic [1:0] c1, input logic [1:0] c2,
                                     input logic [1:0] dc);
    return {op, s1, s2, dst, c1, c2, dc, 2'b00};
  endfunction

  task automatic fill_rom(input logic [39:0] w);
    for (int a = 0; a < 64; a++) rom[a] = w;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    bus.start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    m_pc = 0;
    m_stack.delete();
    m_op = 0; m_s1 = 0; m_s2 = 0; m_dst = 0; m_c1 = 0; m_c2 = 0;
    m_halt = 0; m_err = 0;
  endtask

  // Runs up to max_instr instructions from a fresh start; zmode 0/1 = fixed zero_flag, 2 = random.
  task automatic run(input int max_instr, input int zmode);
    logic [39:0] w;
    logic [7:0]  op;
    int          tgt, nxt;
    logic [1:0]  exp_dc;
    bit          exp_push, exp_pop;
    bit          zf;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int n = 0; n < max_instr && !m_halt; n++) begin
      zf = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      bus.zero_flag = zf;
      chk("fetch_addr", bus.prog_addr, m_pc);
      chk("fetch_dc", bus.dest_choice, 2'b11);
      chk("fetch_busy", bus.busy, 1'b1);
      tick;
      chk("decode_dc", bus.dest_choice, 2'b11);
      chk("decode_push", bus.push, 1'b0);
      tick;
      w = rom[m_pc];
      op = w[39:32];
      tgt = int'(w[13:8]);
      nxt = (m_pc + 1) % 64;
      exp_push = 0;
      exp_pop = 0;
      exp_dc = 2'b11;
      if (op < 8'hF0) begin
        m_op = op; m_s1 = w[31:24]; m_s2 = w[23:16]; m_dst = w[15:8];
        m_c1 = w[7:6]; m_c2 = w[5:4];
        exp_dc = w[3:2];
      end else begin
        case (op)
          8'hF0: nxt = tgt;
          8'hF1: nxt = zf ? tgt : nxt;
          8'hF2: nxt = zf ? nxt : tgt;
          8'hF3: begin
            if (m_stack.size() < 4) begin
              m_stack.push_back(nxt);
              exp_push = 1;
              nxt = tgt;
            end else begin
              m_err = 1; m_halt = 1;
            end
          end
          8'hF4: begin
            if (m_stack.size() > 0) begin
              nxt = m_stack.pop_back();
              exp_pop = 1;
            end else begin
              m_err = 1; m_halt = 1;
            end
          end
          8'hFF: m_halt = 1;
          default: ;
        endcase
      end
      chk("exec_iaddr", bus.instr_addr, m_pc);
      chk("exec_op", bus.op_code, m_op);
      chk("exec_src", {bus.source1, bus.source2}, {m_s1, m_s2});
      chk("exec_choice", {bus.source1_choice, bus.source2_choice}, {m_c1, m_c2});
      chk("exec_dst", bus.destination, m_dst);
      chk("exec_dc", bus.dest_choice, exp_dc);
      chk("exec_push", bus.push, exp_push);
      chk("exec_pop", bus.pop, exp_pop);
      if (!m_halt) m_pc = nxt;
      tick;
      chk("post_halted", bus.halted, m_halt);
      chk("post_err", bus.stack_err, m_err);
      chk("post_dc", bus.dest_choice, 2'b11);
      if (m_halt) chk("post_busy", bus.busy, 1'b0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.zero_flag = 1'b0;
    fill_rom(mk(8'hFF, 0, 0, 0, 0, 0, 0));

    do_reset;
    chk("rst_state", {bus.busy, bus.halted, bus.stack_err, bus.push, bus.pop}, 5'b0);
    chk("rst_dc", bus.dest_choice, 2'b11);
    chk("rst_fields", {bus.op_code, bus.source1, bus.source2, bus.destination}, 32'h0);
    chk("rst_pc", bus.instr_addr, 6'd0);

    // ALU op then JZ taken / not taken
    rom[0] = mk(8'h01, 8'd2, 8'd3, 8'd4, 2'd1, 2'd2, 2'b00);
    rom[1] = mk(8'hF1, 0, 0, 8'd10, 0, 0, 0);
    run(3, 1);
    do_reset;
    run(3, 0);
    do_reset;

    // CALL / RET round trip
    fill_rom(mk(8'hFF, 0, 0, 0, 0, 0, 0));
    rom[0]  = mk(8'hF0, 0, 0, 8'd5, 0, 0, 0);
    rom[5]  = mk(8'hF3, 0, 0, 8'd20, 0, 0, 0);
    rom[20] = mk(8'hF4, 0, 0, 0, 0, 0, 0);
    run(10, 2);
    do_reset;

    // Five nested CALLs overflow the 4-deep stack
    for (int i = 0; i < 5; i++) rom[i] = mk(8'hF3, 0, 0, 8'(i + 1), 0, 0, 0);
    run(10, 0);
    do_reset;

    // RET on empty stack
    rom[0] = mk(8'hF4, 0, 0, 0, 0, 0, 0);
    run(4, 0);
    do_reset;

    // JMP to the last address, ALU op there, pc wraps to 0
    rom[0]  = mk(8'hF0, 0, 0, 8'd63, 0, 0, 0);
    rom[63] = mk(8'h22, 8'h11, 8'h33, 8'h44, 2'd3, 2'd0, 2'b10);
    run(4, 0);
    do_reset;

    // HALT, then start is ignored
    rom[0] = mk(8'hFF, 0, 0, 0, 0, 0, 0);
    run(2, 0);
    bus.start = 1'b1;
    tick; tick; tick;
    bus.start = 1'b0;
    chk("halt_hold", {bus.halted, bus.busy}, 2'b10);
    chk("halt_dc", bus.dest_choice, 2'b11);
    do_reset;

    // Reset during DECODE suppresses the pending EXEC
    rom[0] = mk(8'h05, 8'd7, 8'd8, 8'd9, 0, 0, 2'b00);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("midrst_dc", bus.dest_choice, 2'b11);
    chk("midrst_pc", bus.instr_addr, 6'd0);
    chk("midrst_state", {bus.busy, bus.halted}, 2'b00);
    chk("midrst_op", bus.op_code, 8'h00);
    tick;
    chk("midrst_dc2", bus.dest_choice, 2'b11);
    do_reset;

    // Random programs
    for (int p = 0; p < 25; p++) begin
      for (int a = 0; a < 64; a++) begin
        int r;
        logic [7:0] op;
        r = $urandom_range(0, 9);
        if (r <= 5)      op = 8'($urandom_range(0, 8'hEF));
        else if (r == 6) op = 8'($urandom_range(8'hF0, 8'hF2));
        else if (r == 7) op = 8'hF3;
        else if (r == 8) op = 8'hF4;
        else             op = 8'($urandom_range(8'hF5, 8'hFF));
        rom[a] = mk(op, 8'($urandom), 8'($urandom), 8'($urandom),
                    2'($urandom), 2'($urandom), 2'($urandom));
      end
      run(40, 2);
      do_reset;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
